// File: rtl/aes256_ctr_xor.sv
// AES-256-CTR output stage: buffers keystream blocks from the aes256 core and XORs
// them with AXI-stream plaintext beats to form registered AXI-stream ciphertext.
module aes256_ctr_xor #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pi_clear,
    input  logic                       pi_ks_valid,
    input  logic [127:0]               pi_ks_data,
    output logic [$clog2(DEPTH):0]     po_ks_free,
    output logic                       po_ks_overflow,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tvalid,
    input  logic [127:0]               s_axis_tdata,
    input  logic                       s_axis_tlast,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tvalid,
    output logic [127:0]               m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [CNT_W-1:0]           po_block_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [127:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [FW-1:0]    r_free;
    logic             r_overflow;
    logic             r_m_valid;
    logic [127:0]     r_m_data;
    logic             r_m_last;
    logic [CNT_W-1:0] r_block_count;

    logic             w_empty;
    logic             w_full;
    logic             w_out_ready;
    logic             w_s_ready;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_m_fire;
    logic [127:0]     w_head;

    // Occupancy lives in the free-slot counter, so full/empty never need pointer compares.
    assign w_empty     = (r_free == FW'(DEPTH));
    assign w_full      = (r_free == '0);
    assign w_out_ready = !r_m_valid || m_axis_tready;
    assign w_s_ready   = !w_empty && w_out_ready;
    assign w_pop       = s_axis_tvalid && w_s_ready && !pi_clear;
    assign w_push      = pi_ks_valid && (!w_full || w_pop) && !pi_clear;
    assign w_drop      = pi_ks_valid && w_full && !w_pop && !pi_clear;
    assign w_m_fire    = r_m_valid && m_axis_tready;
    assign w_head      = r_mem[r_rd_ptr];

    // Storage carries no reset; a block is only read after its pointer has advanced past it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pi_ks_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || pi_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_free     <= FW'(DEPTH);
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_free <= r_free - FW'(1);
                2'b01:   r_free <= r_free + FW'(1);
                default: r_free <= r_free;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else if (pi_clear) begin
            r_m_valid <= 1'b0;
        end else if (w_pop) begin
            r_m_valid <= 1'b1;
            r_m_data  <= s_axis_tdata ^ w_head;
            r_m_last  <= s_axis_tlast;
        end else if (w_m_fire) begin
            r_m_valid <= 1'b0;
        end
    end

    // The counter tracks downstream handshakes, so a flush does not rewind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_block_count <= '0;
        end else if (w_m_fire) begin
            r_block_count <= r_block_count + CNT_W'(1);
        end
    end

    assign po_ks_free     = r_free;
    assign po_ks_overflow = r_overflow;
    assign s_axis_tready  = w_s_ready;
    assign m_axis_tvalid  = r_m_valid;
    assign m_axis_tdata   = r_m_data;
    assign m_axis_tlast   = r_m_last;
    assign po_block_count = r_block_count;

endmodule
